riscv_muldiv: RTL and testbench

- Iterative, parametrised RISC-V M-extension unit covering MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the combinational ALU in the next-generation core.
- The core stalls on valid/ready handshakes while this unit computes over multiple cycles.
- Multiply is radix-2 shift-add; divide is radix-2 restoring, on operand magnitudes with a final sign fix-up.

---
 rtl/riscv_muldiv_pkg.sv | 32 +++
 rtl/riscv_muldiv_step.sv | 35 +++
 rtl/riscv_muldiv.sv | 134 +++++++++++++
 tb/tb_riscv_muldiv.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_muldiv_pkg.sv
// Shared encodings for the iterative RISC-V M-extension unit: funct3 opcodes
// and FSM states.
package riscv_muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        MD_MUL    = F3_MUL,
        MD_MULH   = F3_MULH,
        MD_MULHSU = F3_MULHSU,
        MD_MULHU  = F3_MULHU,
        MD_DIV    = F3_DIV,
        MD_DIVU   = F3_DIVU,
        MD_REM    = F3_REM,
        MD_REMU   = F3_REMU
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } md_state_e;

endpackage

// File: rtl/riscv_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring step for divide.
// Accumulator is {upper, lower}; lower holds the multiplier or the quotient.
module riscv_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   upper;
    logic [XLEN+1:0] diff;
    logic            unused_diff_bit;

    always_comb begin
        sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        // upper XLEN+1 bits of the accumulator after a left shift by one
        upper = acc[2*XLEN-1:XLEN-1];
        diff  = {1'b0, upper} - {2'b00, operand};
        if (is_div) begin
            if (diff[XLEN+1])
                acc_next = {upper[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end

    // a non-negative difference is below the divisor, so bit XLEN is always 0
    assign unused_diff_bit = diff[XLEN];

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit with valid/ready handshakes.
// Define RISCV_MULDIV_FASTZERO_EN to short-circuit zero operands to a 1-cycle result.
module riscv_muldiv
    import riscv_muldiv_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state, state_next;
    md_op_e            op;
    logic [CNTW-1:0]   cnt;
    logic              sign;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc, acc_step, prod_fix;
    logic              accept, op_is_div, in_is_div, sa, sb, special;
    logic [XLEN-1:0]   mag_a, mag_b, special_res, fix_res, quo_fix, rem_fix;

    assign in_ready  = (state == IDLE);
    assign busy      = !in_ready;
    assign out_valid = (state == DONE);
    // kill outranks a same-cycle accept
    assign accept    = in_valid && in_ready && !kill;
    assign op_is_div = op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};

    riscv_muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div   (op_is_div),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (acc_step)
    );

    always_comb begin
        in_is_div   = funct3[2];
        sa          = src_a[XLEN-1] && (funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
        sb          = src_b[XLEN-1] && (funct3 inside {F3_MULH, F3_DIV, F3_REM});
        mag_a       = sa ? -src_a : src_a;
        mag_b       = sb ? -src_b : src_b;
        special     = 1'b0;
        special_res = '0;
        if (in_is_div && src_b == '0) begin
            special     = 1'b1;
            special_res = funct3[1] ? src_a : '1;
        end else if ((funct3 == F3_DIV || funct3 == F3_REM) && src_a == MIN_NEG && src_b == '1) begin
            special     = 1'b1;
            special_res = funct3[1] ? '0 : MIN_NEG;
        end
`ifdef RISCV_MULDIV_FASTZERO_EN
        else if (!in_is_div && (src_a == '0 || src_b == '0)) begin
            special = 1'b1;
        end else if (in_is_div && src_a == '0) begin
            special = 1'b1;
        end
`endif
    end

    // multiply negates the full product so the high half is correct too
    always_comb begin
        prod_fix = sign ? -acc : acc;
        quo_fix  = sign ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = sign ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            MD_MUL:                     fix_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:            fix_res = quo_fix;
            default:                    fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: begin
                if (kill)
                    state_next = IDLE;
                else if (cnt == CNTW'(XLEN-1))
                    state_next = FIX;
            end
            FIX:  state_next = kill ? IDLE : DONE;
            DONE: if (kill || out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op     <= MD_MUL;
            cnt    <= '0;
            sign   <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op   <= md_op_e'(funct3);
                    cnt  <= '0;
                    sign <= (in_is_div && funct3[1]) ? sa : (sa ^ sb);
                    acc  <= {{XLEN{1'b0}}, in_is_div ? mag_a : mag_b};
                    opnd <= in_is_div ? mag_b : mag_a;
                    if (special) result <= special_res;
                end
                CALC: if (!kill) begin
                    acc <= acc_step;
                    cnt <= cnt + CNTW'(1);
                end
                FIX: if (!kill) result <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Scoreboard bench for riscv_muldiv (XLEN=32): directed vectors, random ops
// against a plain-arithmetic reference, hold, kill and async reset scenarios.
module tb_riscv_muldiv;

    logic        clk, reset, in_valid, in_ready, kill, out_valid, out_ready, busy;
    logic [2:0]  funct3;
    logic [31:0] src_a, src_b, result;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

`ifdef RISCV_MULDIV_FASTZERO_EN
    localparam int FZ_LAT = 1;
`else
    localparam int FZ_LAT = 34;
`endif

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    riscv_muldiv #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .src_a(src_a), .src_b(src_b), .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hffff_ffff : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hffff_ffff) return 1;
`ifdef RISCV_MULDIV_FASTZERO_EN
        if (!f[2] && (a == 0 || b == 0)) return 1;
        if (f[2] && a == 0) return 1;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hffff_ffff;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // issue one op at posedge+1 and measure edges until out_valid
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("in_ready_before_op", in_ready, 1'b1);
        exp_q.push_back(r);
        in_valid = 1'b1; funct3 = f; src_a = a; src_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("latency", n, lat);
        @(posedge clk); #1;
    endtask

    // scoreboard monitor: a result is consumed when out_valid & out_ready
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result", result, mon_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs = '{
            '{3'd0, 32'd7,         32'hffff_fffd, 32'hffff_ffeb, 34},
            '{3'd1, 32'd7,         32'hffff_fffd, 32'hffff_ffff, 34},
            '{3'd3, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 34},
            '{3'd2, 32'hffff_ffff, 32'd2,         32'hffff_ffff, 34},
            '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34},
            '{3'd4, 32'hffff_fff9, 32'd2,         32'hffff_fffd, 34},
            '{3'd6, 32'hffff_fff9, 32'd2,         32'hffff_ffff, 34},
            '{3'd5, 32'd64,        32'd3,         32'd21,        34},
            '{3'd7, 32'd64,        32'd3,         32'd1,         34},
            '{3'd4, 32'd5,         32'd0,         32'hffff_ffff, 1},
            '{3'd7, 32'd5,         32'd0,         32'd5,         1},
            '{3'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1},
            '{3'd6, 32'h8000_0000, 32'hffff_ffff, 32'd0,         1},
            '{3'd0, 32'd0,         32'h1234,      32'd0,         FZ_LAT}
        };
        reset = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
        funct3 = 3'd0; src_a = '0; src_b = '0;
        #12;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_result", result, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i]) do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            do_op(f, a, b, ref_model(f, a, b), exp_lat(f, a, b));
        end

        // hold the result with out_ready low; in_valid meanwhile must be ignored
        out_ready = 1'b0;
        exp_q.push_back(32'hffff_fffe);
        in_valid = 1'b1; funct3 = 3'd3; src_a = 32'hffff_ffff; src_b = 32'hffff_ffff;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 0; n < 100 && !out_valid; n++) begin @(posedge clk); #1; end
        chk("hold_out_valid", out_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; funct3 = 3'd0; src_a = 32'd1; src_b = 32'd1;
            @(posedge clk); #1;
            chk("hold_result", result, 32'hffff_fffe);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_out_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("release_in_ready_same_cycle", in_ready, 1'b0);
        @(posedge clk); #1;
        chk("release_in_ready", in_ready, 1'b1);
        chk("release_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("no_accept_after_hold", busy, 1'b0);

        // kill in IDLE outranks an accept
        in_valid = 1'b1; kill = 1'b1; funct3 = 3'd5; src_a = 32'd9; src_b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        chk("kill_idle_no_accept", busy, 1'b0);

        // kill during CALC
        in_valid = 1'b1; funct3 = 3'd0; src_a = 32'd123; src_b = 32'd456;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("kill_busy_before", busy, 1'b1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_in_ready", in_ready, 1'b1);
        chk("kill_out_valid", out_valid, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("kill_no_late_valid", out_valid, 1'b0);

        // set a nonzero result, then reset asynchronously mid-CALC
        do_op(3'd5, 32'd64, 32'd3, 32'd21, 34);
        in_valid = 1'b1; funct3 = 3'd4; src_a = 32'd1000; src_b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_in_ready", in_ready, 1'b1);
        chk("async_reset_out_valid", out_valid, 1'b0);
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_result", result, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("post_reset_idle", busy, 1'b0);

        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
